// File: rtl/montgomery_constant_server.sv
// Serves the Montgomery reducer's k and N constant blocks one per consume
// pulse, tracking sweep quotas and flagging protocol violations.
module montgomery_constant_server #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int N_SWEEPS      = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_valid_in,
  input  logic                     load_sel_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  input  logic                     start_in,
  input  logic                     consumed_k_in,
  input  logic                     consumed_N_in,
  output logic [REGISTER_SIZE-1:0] k_block_out,
  output logic [REGISTER_SIZE-1:0] modN_block_out,
  output logic                     k_loaded_out,
  output logic                     N_loaded_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out
);
  localparam int PW = $clog2(NUM_BLOCKS);
  localparam int SW = $clog2(N_SWEEPS + 1);
  localparam logic [PW-1:0] LAST_BLK = PW'(NUM_BLOCKS - 1);
  localparam logic [SW-1:0] N_QUOTA  = SW'(N_SWEEPS);

  typedef enum logic [0:0] { ST_IDLE = 1'b0, ST_SERVE = 1'b1 } state_t;

  logic [REGISTER_SIZE-1:0] k_mem_r [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] n_mem_r [NUM_BLOCKS];

  state_t        state_r;
  logic [PW-1:0] k_wptr_r, n_wptr_r, k_rptr_r, n_rptr_r;
  logic          k_loaded_r, n_loaded_r;
  logic          k_sweeps_r;
  logic [SW-1:0] n_sweeps_r;
  logic          busy_r, done_r, error_r;

  logic          k_wr_s, n_wr_s;
  logic [PW-1:0] k_rptr_nxt_s, n_rptr_nxt_s;
  logic          k_sweeps_nxt_s;
  logic [SW-1:0] n_sweeps_nxt_s;
  logic          k_over_s, n_over_s, quota_met_s;

  // Writes are only honoured while no reduction is in flight
  always_comb begin
    k_wr_s = load_valid_in & ~busy_r & ~load_sel_in;
    n_wr_s = load_valid_in & ~busy_r &  load_sel_in;
  end

  // k stream advance: one sweep allowed, extra consumes are overruns
  always_comb begin
    k_rptr_nxt_s   = k_rptr_r;
    k_sweeps_nxt_s = k_sweeps_r;
    k_over_s       = 1'b0;
    if (!consumed_k_in) begin
      k_over_s = 1'b0;
    end else if (k_sweeps_r) begin
      k_over_s = 1'b1;
    end else if (k_rptr_r == LAST_BLK) begin
      k_rptr_nxt_s   = '0;
      k_sweeps_nxt_s = 1'b1;
    end else begin
      k_rptr_nxt_s = k_rptr_r + PW'(1);
    end
  end

  // N stream advance: multiplier, comparator and subtractor each sweep once
  always_comb begin
    n_rptr_nxt_s   = n_rptr_r;
    n_sweeps_nxt_s = n_sweeps_r;
    n_over_s       = 1'b0;
    if (!consumed_N_in) begin
      n_over_s = 1'b0;
    end else if (n_sweeps_r == N_QUOTA) begin
      n_over_s = 1'b1;
    end else if (n_rptr_r == LAST_BLK) begin
      n_rptr_nxt_s   = '0;
      n_sweeps_nxt_s = n_sweeps_r + SW'(1);
    end else begin
      n_rptr_nxt_s = n_rptr_r + PW'(1);
    end
    quota_met_s = k_sweeps_nxt_s && (n_sweeps_nxt_s == N_QUOTA);
  end

  // Constant storage; contents deliberately survive reset
  always_ff @(posedge clk_in) begin
    if (k_wr_s) k_mem_r[k_wptr_r] <= load_block_in;
    if (n_wr_s) n_mem_r[n_wptr_r] <= load_block_in;
  end

  // Load bookkeeping, serving FSM and sticky error flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      k_wptr_r   <= '0;
      n_wptr_r   <= '0;
      k_rptr_r   <= '0;
      n_rptr_r   <= '0;
      k_loaded_r <= 1'b0;
      n_loaded_r <= 1'b0;
      k_sweeps_r <= 1'b0;
      n_sweeps_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      if (k_wr_s) begin
        if (k_wptr_r == LAST_BLK) begin
          k_loaded_r <= 1'b1;
          k_wptr_r   <= '0;
        end else begin
          if (k_wptr_r == '0) k_loaded_r <= 1'b0;
          k_wptr_r <= k_wptr_r + PW'(1);
        end
      end
      if (n_wr_s) begin
        if (n_wptr_r == LAST_BLK) begin
          n_loaded_r <= 1'b1;
          n_wptr_r   <= '0;
        end else begin
          if (n_wptr_r == '0) n_loaded_r <= 1'b0;
          n_wptr_r <= n_wptr_r + PW'(1);
        end
      end
      if (load_valid_in && busy_r) error_r <= 1'b1;

      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_in) begin
            if (k_loaded_r && n_loaded_r) begin
              state_r    <= ST_SERVE;
              busy_r     <= 1'b1;
              k_rptr_r   <= '0;
              n_rptr_r   <= '0;
              k_sweeps_r <= 1'b0;
              n_sweeps_r <= '0;
            end else begin
              error_r <= 1'b1;
            end
          end else if (consumed_k_in || consumed_N_in) begin
            error_r <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (start_in) begin
            // Restart drops any same-cycle consume
            k_rptr_r   <= '0;
            n_rptr_r   <= '0;
            k_sweeps_r <= 1'b0;
            n_sweeps_r <= '0;
            error_r    <= 1'b1;
            done_r     <= 1'b0;
          end else begin
            k_rptr_r   <= k_rptr_nxt_s;
            n_rptr_r   <= n_rptr_nxt_s;
            k_sweeps_r <= k_sweeps_nxt_s;
            n_sweeps_r <= n_sweeps_nxt_s;
            if (k_over_s || n_over_s) error_r <= 1'b1;
            if (quota_met_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              done_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          error_r <= 1'b1;
        end
      endcase
    end
  end

  assign k_block_out    = k_loaded_r ? k_mem_r[k_rptr_r] : '0;
  assign modN_block_out = n_loaded_r ? n_mem_r[n_rptr_r] : '0;
  assign k_loaded_out   = k_loaded_r;
  assign N_loaded_out   = n_loaded_r;
  assign busy_out       = busy_r;
  assign done_out       = done_r;
  assign error_out      = error_r;

endmodule

// File: tb/tb_montgomery_constant_server.sv
// Scoreboard bench: a count-based reference model predicts every cycle's
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_montgomery_constant_server;
  localparam int RS = 32;
  localparam int NB = 128;
  localparam int NS = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          load_valid_in = 1'b0, load_sel_in = 1'b0;
  logic [RS-1:0] load_block_in = '0;
  logic          start_in = 1'b0, consumed_k_in = 1'b0, consumed_N_in = 1'b0;
  logic [RS-1:0] k_block_out, modN_block_out;
  logic          k_loaded_out, N_loaded_out, busy_out, done_out, error_out;

  montgomery_constant_server #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .N_SWEEPS(NS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_valid_in(load_valid_in),
    .load_sel_in(load_sel_in), .load_block_in(load_block_in), .start_in(start_in),
    .consumed_k_in(consumed_k_in), .consumed_N_in(consumed_N_in),
    .k_block_out(k_block_out), .modN_block_out(modN_block_out),
    .k_loaded_out(k_loaded_out), .N_loaded_out(N_loaded_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out));

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [RS-1:0] kb;
    logic [RS-1:0] nb;
    logic kl, nl, busy, done, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_seen = 0;
  logic rst_drv = 1'b0;

  // Reference model: progress kept as plain consume counts per reduction
  logic [RS-1:0] m_mem [2][NB];
  int m_wcnt [2];
  bit m_loaded [2];
  bit m_busy, m_done, m_err;
  int m_kc, m_nc;

  task automatic chk(input string nm, input logic [RS-1:0] act, input logic [RS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt[0] = 0; m_wcnt[1] = 0;
    m_loaded[0] = 0; m_loaded[1] = 0;
    m_busy = 0; m_done = 0; m_err = 0;
    m_kc = 0; m_nc = 0;
  endtask

  task automatic model_edge();
    bit pre_busy, pre_kl, pre_nl;
    int s;
    if (!rst_in) begin
      model_reset();
      return;
    end
    pre_busy = m_busy; pre_kl = m_loaded[0]; pre_nl = m_loaded[1];
    m_done = 0;
    if (load_valid_in) begin
      if (pre_busy) m_err = 1;
      else begin
        s = load_sel_in ? 1 : 0;
        m_mem[s][m_wcnt[s]] = load_block_in;
        if (m_wcnt[s] == 0) m_loaded[s] = 0;
        m_wcnt[s]++;
        if (m_wcnt[s] == NB) begin
          m_loaded[s] = 1;
          m_wcnt[s] = 0;
        end
      end
    end
    if (start_in) begin
      if (pre_busy) begin m_kc = 0; m_nc = 0; m_err = 1; end
      else if (pre_kl && pre_nl) begin m_busy = 1; m_kc = 0; m_nc = 0; end
      else m_err = 1;
    end else if (pre_busy) begin
      if (consumed_k_in) begin if (m_kc < NB) m_kc++; else m_err = 1; end
      if (consumed_N_in) begin if (m_nc < NS * NB) m_nc++; else m_err = 1; end
      if (m_kc == NB && m_nc == NS * NB) begin m_busy = 0; m_done = 1; end
    end else if (consumed_k_in || consumed_N_in) begin
      m_err = 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.kl   = m_loaded[0];
    e.nl   = m_loaded[1];
    e.kb   = m_loaded[0] ? m_mem[0][m_kc % NB] : '0;
    e.nb   = m_loaded[1] ? m_mem[1][m_nc % NB] : '0;
    e.busy = m_busy;
    e.done = m_done;
    e.err  = m_err;
    return e;
  endfunction

  task automatic cyc(input logic lv, input logic ls, input logic [RS-1:0] lb,
                     input logic st, input logic ck, input logic cn);
    @(negedge clk_in);
    rst_in = rst_drv;
    load_valid_in = lv; load_sel_in = ls; load_block_in = lb;
    start_in = st; consumed_k_in = ck; consumed_N_in = cn;
    @(posedge clk_in);
    model_edge();
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_const(input logic sel, input logic [RS-1:0] base, input bit rnd);
    for (int i = 0; i < NB; i++)
      cyc(1'b1, sel, rnd ? RS'($urandom) : base + RS'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    rst_drv = 1'b0;
    #1;
    chk("arst_k_block", k_block_out, '0);
    chk("arst_n_block", modN_block_out, '0);
    chk("arst_busy", {31'd0, busy_out}, '0);
    chk("arst_error", {31'd0, error_out}, '0);
    chk("arst_loaded", {30'd0, k_loaded_out, N_loaded_out}, '0);
    model_reset();
  endtask

  task automatic fresh();
    async_reset();
    idle(); idle();
    rst_drv = 1'b1;
    idle();
    load_const(1'b0, 32'h1000_0000, 0);
    load_const(1'b1, 32'h2000_0000, 0);
  endtask

  // Monitor: compare every presented cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("k_block", k_block_out, e.kb);
        chk("n_block", modN_block_out, e.nb);
        chk("k_loaded", {31'd0, k_loaded_out}, {31'd0, e.kl});
        chk("n_loaded", {31'd0, N_loaded_out}, {31'd0, e.nl});
        chk("busy", {31'd0, busy_out}, {31'd0, e.busy});
        chk("done", {31'd0, done_out}, {31'd0, e.done});
        chk("error", {31'd0, error_out}, {31'd0, e.err});
        if (done_out) done_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) idle();
    rst_drv = 1'b1;
    idle();
    load_const(1'b0, 32'h1000_0000, 0);
    load_const(1'b1, 32'h2000_0000, 0);
    #2;
    chk("both_loaded", {30'd0, k_loaded_out, N_loaded_out}, 32'd3);

    // Full legal reduction: k swept back-to-back, N swept three times with gaps
    done_seen = 0;
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("start_block0", k_block_out, 32'h1000_0000);
    for (int i = 0; i < NB; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("k_wrapped", k_block_out, 32'h1000_0000);
    for (int i = 0; i < NS * NB; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle(); idle();
    #2;
    chk("done_once", 32'(done_seen), 32'd1);
    chk("clean_error", {31'd0, error_out}, '0);

    // Overrun on k: pointer holds, N unaffected
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, i % 3 == 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    #2;
    chk("overrun_error", {31'd0, error_out}, 32'd1);
    chk("overrun_k_hold", k_block_out, 32'h1000_0000);
    repeat (4) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Restart colliding with an N consume at block 5
    fresh();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    #2;
    chk("restart_n_block", modN_block_out, 32'h2000_0000);
    chk("restart_error", {31'd0, error_out}, 32'd1);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Load during SERVE is dropped; wrap k to read block 0 again
    fresh();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("load_busy_error", {31'd0, error_out}, 32'd1);
    chk("k0_unchanged", k_block_out, 32'h1000_0000);
    repeat (4) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Start with only k loaded
    async_reset();
    idle();
    rst_drv = 1'b1;
    idle();
    load_const(1'b0, 32'h1000_0000, 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("k_only_busy", {31'd0, busy_out}, '0);
    chk("k_only_error", {31'd0, error_out}, 32'd1);

    // Asynchronous reset mid-sweep wipes loaded status
    fresh();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (40) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    async_reset();
    idle();
    rst_drv = 1'b1;
    idle();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("post_rst_start_error", {31'd0, error_out}, 32'd1);

    // Random legal traffic over random constants
    async_reset();
    idle();
    rst_drv = 1'b1;
    idle();
    load_const(1'b0, '0, 1);
    load_const(1'b1, '0, 1);
    for (int i = 0; i < 1500; i++)
      cyc(1'b0, 1'b0, '0,
          !m_busy && ($urandom_range(0, 3) == 0),
          m_busy && (m_kc < NB) && ($urandom_range(0, 1) == 0),
          m_busy && (m_nc < NS * NB) && ($urandom_range(0, 3) != 0));

    // Random traffic with protocol violations mixed in
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, RS'($urandom),
          $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

    idle();
    @(negedge clk_in);
    #1;
    chk("queue_drained", 32'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/montgomery_constant_server.md
# montgomery_constant_server

Responder for the Montgomery reducer's constant-block streams. It holds the two `R`-bit reduction constants, `k` and the modulus `N` (typically n²), in internal block arrays. It presents the current block of each constant on a free-running output and advances that stream by one block after each `consumed` pulse from the reducer. It also tracks the sweeps the reducer makes over each constant: one over `k` and three over `N` (multiplier, comparator, subtractor). It flags protocol violations and reports when one reduction's constant traffic is complete.

## Interface
- `REGISTER_SIZE`, 32, bits per block.
- `NUM_BLOCKS`, 128, blocks per constant (R / `REGISTER_SIZE`, i.e. 4096 bits).
- `N_SWEEPS`, 3, full passes over `N` per reduction.

- `clk_in` input 1: single clock; all state on rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `load_valid_in` input 1: write one constant block this cycle.
- `load_sel_in` input 1: 0 = `k`, 1 = `N`.
- `load_block_in` input `REGISTER_SIZE`: block data, least-significant block first.
- `start_in` input 1: one-cycle pulse, asserted on or before the reducer's first T block; begins a reduction.
- `consumed_k_in` input 1: reducer consumed the current `k` block.
- `consumed_N_in` input 1: reducer consumed the current `N` block.
- `k_block_out` output `REGISTER_SIZE`: current `k` block.
- `modN_block_out` output `REGISTER_SIZE`: current `N` block.
- `k_loaded_out`, `N_loaded_out` output 1: the constant is fully loaded.
- `busy_out` output 1: a reduction is in progress.
- `done_out` output 1: one-cycle pulse when the reduction's constant traffic is complete.
- `error_out` output 1: sticky protocol-violation flag; cleared only by reset.

## Operation
- Storage: two arrays, `NUM_BLOCKS` x `REGISTER_SIZE` each, with combinational read at the read pointer. Array contents are not reset.
- Per-stream state:
  - write pointer `wptr_k` / `wptr_N`;
  - read pointer `rptr_k` / `rptr_N`, 0..`NUM_BLOCKS`-1;
  - loaded flag;
  - sweep counters: `sweeps_k` 0..1, `sweeps_N` 0..`N_SWEEPS`.
- Load (allowed only while `busy_out`=0):
  - A write stores `load_block_in` at `wptr` of the selected stream, then increments `wptr`.
  - A write with `wptr`=0 clears that stream's loaded flag.
  - The write that fills the last block (`wptr`=`NUM_BLOCKS`-1) sets the loaded flag and returns `wptr` to 0.
  - `load_valid_in` while `busy_out`=1: write ignored, `error_out` set.
- Outputs: `k_block_out` = `k_loaded_out` ? `k[rptr_k]` : 0. `modN_block_out` follows the same rule for `N`.
- FSM states: IDLE, SERVE.
  - IDLE → SERVE on `start_in` when both loaded flags are set. Both read pointers and both sweep counters go to 0; `busy_out` goes to 1.
  - `start_in` with either constant unloaded: stay in IDLE, set `error_out`.
  - `start_in` while in SERVE: restart. Pointers and counters go to 0, `error_out` is set, and the FSM stays in SERVE.
  - SERVE, consume on a stream:
    - If the stream's sweep quota is not yet met: the pointer increments.
    - At `NUM_BLOCKS`-1 the pointer wraps to 0 and the sweep counter increments.
    - If the quota is already met (`k` 1, `N` `N_SWEEPS`): the pointer holds and `error_out` is set.
  - SERVE → IDLE in the cycle the final quota is met, either by a completing consume or by the other stream already being complete. `done_out` pulses for one cycle and `busy_out` falls.
  - Consume pulse in IDLE: ignored, `error_out` set.
- Streams are independent. `consumed_k_in` and `consumed_N_in` may assert in the same cycle.
- `start_in` and a consume in the same cycle: `start_in` wins and the consume is dropped.

## Timing
- Reset values:
  - all `wptr` and `rptr` 0; loaded flags 0; FSM IDLE;
  - `busy_out` 0, `done_out` 0, `error_out` 0;
  - `k_block_out` and `modN_block_out` 0 (gated by the loaded flags).
- Reset mid-operation discards all progress, including loaded status. Constants must be reloaded.
- Consume handshake, zero-latency response:
  - A consume at edge c makes block `rptr`+1 visible on the output after edge c, i.e. in cycle c+1.
  - A consume may assert every cycle.
- `start_in` at edge c: block 0 is visible in cycle c+1 and `busy_out`=1 from c+1.
- `done_out` is high in the cycle after the completing consume edge, concurrent with `busy_out` falling to 0.
- Load: a write at edge c is readable at cycle c+1. The loaded flag rises in the cycle after the last write.
- No backpressure: the reducer can never stall on this block.

## Test plan
- Load `k[i]`=0x1000_0000+i and `N[i]`=0x2000_0000+i; pulse `start_in`; assert `consumed_k_in` for 128 consecutive cycles → `k_block_out` steps 0x1000_0000..0x1000_007F, one per cycle, then stays 0x1000_0000.
- Same load; 384 `consumed_N_in` pulses with gaps, plus 128 `k` pulses → `N` sequence 0x2000_0000..0x2000_007F three times; `done_out` is a single pulse after the later of the last `k` and last `N` consume; `busy_out` then 0; `error_out` 0.
- 129th `consumed_k_in` → `rptr_k` holds at 0; `error_out`=1 the next cycle; `N` stream unaffected.
- `start_in` together with `consumed_N_in` at `rptr_N`=5 → `modN_block_out`=0x2000_0000 next cycle; sweep counters are 0; `error_out`=1.
- `load_valid_in` during SERVE → array unchanged (subsequent reads return the original values); `error_out`=1. `start_in` with only `k` loaded → stays IDLE; `busy_out`=0; `error_out`=1.
- Drive `rst_in` low mid-sweep → all outputs 0 immediately (asynchronous); after release, `start_in` → error set, because the loaded flags were cleared.
